// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin credit, vend handshake and one-coin-at-a-time change/refund.
// Optional `SALES_TOTAL_EN adds a wrapping sales_total counter of vended prices.
module vend_sequencer #(
    parameter int CREDIT_W    = 11,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int SALES_W     = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CREDIT_W-1:0] price,
    input  logic                coin_dollar,
    input  logic                coin_quarter,
    input  logic                coin_dime,
    input  logic                coin_nickel,
    input  logic                cancel,
    output logic                vend_req,
    input  logic                vend_ack,
    output logic                eject_req,
    output logic [1:0]          eject_coin,
    input  logic                eject_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                l_select,
    output logic                l_pay,
    output logic                l_vend,
`ifdef SALES_TOTAL_EN
    output logic [SALES_W-1:0]  sales_total,
`endif
    output logic [2:0]          state_dbg
);

    // Handshakes: vend_req/eject_req rise and hold until the matching one-cycle ack
    // is sampled while the request is high; the request drops on the following cycle.
    typedef enum logic [2:0] {S_IDLE, S_PAY, S_VEND, S_CHANGE, S_DONE} state_t;

    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [CREDIT_W:0]   SUM_100    = (CREDIT_W+1)'(100);
    localparam logic [CREDIT_W:0]   SUM_25     = (CREDIT_W+1)'(25);
    localparam logic [CREDIT_W:0]   SUM_10     = (CREDIT_W+1)'(10);
    localparam logic [CREDIT_W:0]   SUM_5      = (CREDIT_W+1)'(5);
    localparam logic [CREDIT_W-1:0] C_100      = CREDIT_W'(100);
    localparam logic [CREDIT_W-1:0] C_25       = CREDIT_W'(25);
    localparam logic [CREDIT_W-1:0] C_10       = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] C_5        = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

    state_t              state;
    logic [TO_W-1:0]     to_cnt;
    logic [CREDIT_W-1:0] price_l;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W:0]   sum_raw;
    logic [CREDIT_W-1:0] credit_add;
    logic                coin_any;
    logic                timeout_hit;
    logic [1:0]          sel_coin;
    logic [CREDIT_W-1:0] ej_val;

    always_comb begin
        coin_sum = '0;
        if (coin_dollar)  coin_sum = coin_sum + SUM_100;
        if (coin_quarter) coin_sum = coin_sum + SUM_25;
        if (coin_dime)    coin_sum = coin_sum + SUM_10;
        if (coin_nickel)  coin_sum = coin_sum + SUM_5;
        coin_any    = coin_dollar | coin_quarter | coin_dime | coin_nickel;
        sum_raw     = {1'b0, credit} + coin_sum;
        credit_add  = sum_raw[CREDIT_W] ? CREDIT_MAX : sum_raw[CREDIT_W-1:0];
        timeout_hit = (TIMEOUT_CYC != 0) && !coin_any && (to_cnt == TO_LAST);
    end

    // Greedy change: largest coin that still fits the remaining amount.
    always_comb begin
        sel_coin = 2'd3;
        if (credit >= C_100)     sel_coin = 2'd0;
        else if (credit >= C_25) sel_coin = 2'd1;
        else if (credit >= C_10) sel_coin = 2'd2;
        case (eject_coin)
            2'd0:    ej_val = C_100;
            2'd1:    ej_val = C_25;
            2'd2:    ej_val = C_10;
            default: ej_val = C_5;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            credit     <= '0;
            price_l    <= '0;
            to_cnt     <= '0;
            vend_req   <= 1'b0;
            eject_req  <= 1'b0;
            eject_coin <= 2'd0;
`ifdef SALES_TOTAL_EN
            sales_total <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (price != '0) begin
                        state  <= S_PAY;
                        credit <= '0;
                        to_cnt <= '0;
                    end
                end
                S_PAY: begin
                    credit <= credit_add;
                    to_cnt <= coin_any ? '0 : to_cnt + TO_W'(1);
                    if (cancel || (price == '0) || timeout_hit) begin
                        state <= S_CHANGE;
                    end else if (credit_add >= price) begin
                        price_l  <= price;
                        vend_req <= 1'b1;
                        state    <= S_VEND;
                    end
                end
                S_VEND: begin
                    if (vend_ack) begin
                        vend_req <= 1'b0;
                        credit   <= credit - price_l;
                        state    <= S_CHANGE;
`ifdef SALES_TOTAL_EN
                        sales_total <= sales_total + SALES_W'(price_l);
`endif
                    end
                end
                S_CHANGE: begin
                    // eject_req low for one cycle after each ack before the next coin.
                    if (eject_req) begin
                        if (eject_ack) begin
                            credit    <= credit - ej_val;
                            eject_req <= 1'b0;
                        end
                    end else if (credit >= C_5) begin
                        eject_req  <= 1'b1;
                        eject_coin <= sel_coin;
                    end else begin
                        credit <= '0;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    credit <= '0;
                    if (price == '0) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign l_select  = (state == S_IDLE);
    assign l_pay     = (state == S_PAY);
    assign l_vend    = (state == S_VEND) || (state == S_CHANGE) || (state == S_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed scenarios plus randomized transactions against a
// transaction-level model (saturating credit sum, greedy change list, wrapping sales sum).
module tb_vend_sequencer;

    localparam int CW  = 11;
    localparam int SW  = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] price = '0;
    logic          coin_dollar = 1'b0, coin_quarter = 1'b0, coin_dime = 1'b0, coin_nickel = 1'b0;
    logic          cancel = 1'b0;
    logic          vend_req;
    logic          vend_ack = 1'b0;
    logic          eject_req;
    logic [1:0]    eject_coin;
    logic          eject_ack = 1'b0;
    logic [CW-1:0] credit;
    logic          l_select, l_pay, l_vend;
    logic [2:0]    state_dbg;
`ifdef SALES_TOTAL_EN
    logic [SW-1:0] sales_total;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int vend_hi = 0;
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];

    vend_sequencer #(.CREDIT_W(CW), .TIMEOUT_CYC(16), .SALES_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .price(price),
        .coin_dollar(coin_dollar), .coin_quarter(coin_quarter),
        .coin_dime(coin_dime), .coin_nickel(coin_nickel), .cancel(cancel),
        .vend_req(vend_req), .vend_ack(vend_ack),
        .eject_req(eject_req), .eject_coin(eject_coin), .eject_ack(eject_ack),
        .credit(credit), .l_select(l_select), .l_pay(l_pay), .l_vend(l_vend),
`ifdef SALES_TOTAL_EN
        .sales_total(sales_total),
`endif
        .state_dbg(state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) if (vend_req) vend_hi = vend_hi + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        price = '0;
        cancel = 1'b0; vend_ack = 1'b0; eject_ack = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_coins(input logic d, input logic q, input logic di, input logic n);
        coin_dollar = d; coin_quarter = q; coin_dime = di; coin_nickel = n;
        tick();
        coin_dollar = 1'b0; coin_quarter = 1'b0; coin_dime = 1'b0; coin_nickel = 1'b0;
    endtask

    task automatic do_vend_ack();
        repeat ($urandom_range(0, 3)) tick();
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
    endtask

    // Serves the hopper until change is exhausted; stray acks are thrown in while no request is up.
    task automatic collect_change(output bit timed_out);
        got_q.delete();
        timed_out = 1'b0;
        for (int b = 0; b < 400; b++) begin
            if (credit == '0 && !eject_req) return;
            if (eject_req) begin
                repeat ($urandom_range(0, 2)) tick();
                got_q.push_back(eject_coin);
                eject_ack = 1'b1;
                tick();
                eject_ack = 1'b0;
            end else begin
                eject_ack = 1'($urandom_range(0, 1));
                tick();
                eject_ack = 1'b0;
            end
        end
        timed_out = 1'b1;
    endtask

    task automatic finish_txn();
        price = '0;
        repeat (2) tick();
    endtask

    // Reference model
    function automatic void greedy_change(input int amt);
        exp_q.delete();
        while (amt >= 5) begin
            if (amt >= 100)     begin exp_q.push_back(2'd0); amt -= 100; end
            else if (amt >= 25) begin exp_q.push_back(2'd1); amt -= 25;  end
            else if (amt >= 10) begin exp_q.push_back(2'd2); amt -= 10;  end
            else                begin exp_q.push_back(2'd3); amt -= 5;   end
        end
    endfunction

    function automatic bit queues_match();
        if (got_q.size() != exp_q.size()) return 1'b0;
        foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Scenario tasks
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        tests_run++;
        if ({l_select, l_pay, l_vend} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_lamps: got %b expected 100", {l_select, l_pay, l_vend});
        end
        tests_run++;
        if (credit !== '0 || vend_req !== 1'b0 || eject_req !== 1'b0 || eject_coin !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: credit=%0d vend_req=%b eject_req=%b eject_coin=%0d expected 0 0 0 0",
                     credit, vend_req, eject_req, eject_coin);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_vend();
        bit to;
        price = 120;
        tick();
        tests_run++;
        if (l_pay !== 1'b1 || l_select !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_pay_entry: l_pay=%b l_select=%b expected 1 0", l_pay, l_select);
        end
        pulse_coins(1, 0, 0, 0);
        tests_run++;
        if (credit !== 11'd100) begin
            tests_failed++;
            $display("FAIL basic_credit_dollar: got %0d expected 100", credit);
        end
        pulse_coins(0, 1, 0, 0);
        tests_run++;
        if (credit !== 11'd125 || vend_req !== 1'b1 || l_vend !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_vend_entry: credit=%0d vend_req=%b l_vend=%b expected 125 1 1",
                     credit, vend_req, l_vend);
        end
        do_vend_ack();
        tests_run++;
        if (vend_req !== 1'b0 || credit !== 11'd5) begin
            tests_failed++;
            $display("FAIL basic_after_ack: vend_req=%b credit=%0d expected 0 5", vend_req, credit);
        end
        collect_change(to);
        greedy_change(5);
        tests_run++;
        if (to || !queues_match()) begin
            tests_failed++;
            $display("FAIL basic_change: got %0d coins (first %0d) timeout=%b expected 1 coin (3)",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 2'd0, to);
        end
        finish_txn();
        tests_run++;
        if (l_select !== 1'b1 || credit !== '0) begin
            tests_failed++;
            $display("FAIL basic_idle_return: l_select=%b credit=%0d expected 1 0", l_select, credit);
        end
    endtask

    task automatic test_multi_coin();
        bit to;
        price = 55;
        tick();
        pulse_coins(1, 0, 1, 1);
        tests_run++;
        if (credit !== 11'd115 || vend_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL multi_coin_sum: credit=%0d vend_req=%b expected 115 1", credit, vend_req);
        end
        do_vend_ack();
        collect_change(to);
        greedy_change(60);
        tests_run++;
        if (to || !queues_match()) begin
            tests_failed++;
            $display("FAIL multi_coin_change: got %0d coins timeout=%b expected %0d coins (1,1,2)",
                     got_q.size(), to, exp_q.size());
        end
        finish_txn();
    endtask

    task automatic test_cancel();
        bit to;
        vend_hi = 0;
        price = 300;
        tick();
        pulse_coins(1, 0, 0, 0);
        pulse_coins(1, 0, 0, 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tests_run++;
        if (l_vend !== 1'b1 || credit !== 11'd200) begin
            tests_failed++;
            $display("FAIL cancel_refund_entry: l_vend=%b credit=%0d expected 1 200", l_vend, credit);
        end
        collect_change(to);
        greedy_change(200);
        tests_run++;
        if (to || !queues_match() || vend_hi != 0 || credit !== '0) begin
            tests_failed++;
            $display("FAIL cancel_refund: coins=%0d vend_req_cycles=%0d credit=%0d expected 2 0 0",
                     got_q.size(), vend_hi, credit);
        end
        finish_txn();
    endtask

    task automatic test_timeout();
        bit to;
        price = 240;
        tick();
        pulse_coins(0, 0, 1, 0);
        repeat (15) tick();
        tests_run++;
        if (l_pay !== 1'b1 || credit !== 11'd10) begin
            tests_failed++;
            $display("FAIL timeout_early: l_pay=%b credit=%0d expected 1 10", l_pay, credit);
        end
        tick();
        tests_run++;
        if (l_vend !== 1'b1 || vend_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_fire: l_vend=%b vend_req=%b expected 1 0", l_vend, vend_req);
        end
        collect_change(to);
        greedy_change(10);
        tests_run++;
        if (to || !queues_match()) begin
            tests_failed++;
            $display("FAIL timeout_refund: got %0d coins timeout=%b expected 1 dime", got_q.size(), to);
        end
        repeat (10) tick();
        tests_run++;
        if (l_vend !== 1'b1 || l_pay !== 1'b0 || credit !== '0) begin
            tests_failed++;
            $display("FAIL timeout_done_hold: l_vend=%b l_pay=%b credit=%0d expected 1 0 0", l_vend, l_pay, credit);
        end
        finish_txn();
        tests_run++;
        if (l_select !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_idle: l_select=%b expected 1", l_select);
        end
    endtask

    task automatic test_ignored_inputs();
        bit to;
        price = '0;
        pulse_coins(1, 1, 1, 1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tests_run++;
        if (credit !== '0 || l_select !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_coins_ignored: credit=%0d l_select=%b expected 0 1", credit, l_select);
        end
        price = 35;
        tick();
        pulse_coins(0, 1, 1, 0);
        pulse_coins(1, 0, 0, 0);
        cancel = 1'b1;
        price = 5;
        tick();
        cancel = 1'b0;
        tests_run++;
        if (credit !== 11'd35 || vend_req !== 1'b1 || l_vend !== 1'b1) begin
            tests_failed++;
            $display("FAIL vend_coins_ignored: credit=%0d vend_req=%b l_vend=%b expected 35 1 1",
                     credit, vend_req, l_vend);
        end
        do_vend_ack();
        collect_change(to);
        tests_run++;
        if (to || got_q.size() != 0 || credit !== '0) begin
            tests_failed++;
            $display("FAIL vend_latched_price: coins=%0d credit=%0d expected 0 0", got_q.size(), credit);
        end
        finish_txn();
    endtask

    task automatic test_saturation();
        bit to;
        price = 11'(MAXC);
        tick();
        repeat (20) pulse_coins(1, 0, 0, 0);
        tests_run++;
        if (credit !== 11'd2000 || l_pay !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_accumulate: credit=%0d l_pay=%b expected 2000 1", credit, l_pay);
        end
        pulse_coins(1, 0, 0, 0);
        tests_run++;
        if (credit !== 11'(MAXC) || vend_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_clamp: credit=%0d vend_req=%b expected %0d 1", credit, vend_req, MAXC);
        end
        do_vend_ack();
        collect_change(to);
        finish_txn();
    endtask

    task automatic test_random();
        bit to;
        for (int t = 0; t < 25; t++) begin
            int price_m, credit_m, cancel_at, steps, change_m;
            bit vended;
            logic d, q, di, n;
            price_m  = 5 * $urandom_range(1, 60);
            credit_m = 0;
            steps    = 0;
            vended   = 1'b0;
            cancel_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1;
            price = 11'(price_m);
            tick();
            for (int s = 0; s < 200; s++) begin
                repeat ($urandom_range(0, 3)) tick();
                if (steps == cancel_at) begin
                    cancel = 1'b1;
                    tick();
                    cancel = 1'b0;
                    break;
                end
                do begin
                    d = 1'($urandom_range(0, 1)); q = 1'($urandom_range(0, 1));
                    di = 1'($urandom_range(0, 1)); n = 1'($urandom_range(0, 1));
                end while (!(d | q | di | n));
                pulse_coins(d, q, di, n);
                credit_m += 100 * d + 25 * q + 10 * di + 5 * n;
                if (credit_m > MAXC) credit_m = MAXC;
                steps++;
                if (credit_m >= price_m) begin
                    vended = 1'b1;
                    break;
                end
                tests_run++;
                if (credit !== 11'(credit_m) || l_pay !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rand_credit[%0d]: credit=%0d l_pay=%b expected %0d 1", t, credit, l_pay, credit_m);
                end
            end
            if (vended) begin
                tests_run++;
                if (vend_req !== 1'b1 || credit !== 11'(credit_m)) begin
                    tests_failed++;
                    $display("FAIL rand_vend[%0d]: vend_req=%b credit=%0d expected 1 %0d", t, vend_req, credit, credit_m);
                end
                do_vend_ack();
                change_m = credit_m - price_m;
            end else begin
                tests_run++;
                if (l_vend !== 1'b1 || vend_req !== 1'b0 || credit !== 11'(credit_m)) begin
                    tests_failed++;
                    $display("FAIL rand_cancel[%0d]: l_vend=%b vend_req=%b credit=%0d expected 1 0 %0d",
                             t, l_vend, vend_req, credit, credit_m);
                end
                change_m = credit_m;
            end
            collect_change(to);
            greedy_change(change_m);
            tests_run++;
            if (to || !queues_match()) begin
                tests_failed++;
                $display("FAIL rand_change[%0d]: got %0d coins timeout=%b expected %0d coins for %0d cents",
                         t, got_q.size(), to, exp_q.size(), change_m);
            end
            finish_txn();
            tests_run++;
            if (l_select !== 1'b1 || credit !== '0) begin
                tests_failed++;
                $display("FAIL rand_idle[%0d]: l_select=%b credit=%0d expected 1 0", t, l_select, credit);
            end
        end
    endtask

    task automatic test_reset_mid_change();
        bit seen;
        seen = 1'b0;
        price = 55;
        tick();
        pulse_coins(1, 0, 0, 0);
        do_vend_ack();
        for (int b = 0; b < 10 && !seen; b++) begin
            if (eject_req) seen = 1'b1;
            else tick();
        end
        tests_run++;
        if (!seen || eject_coin !== 2'd1) begin
            tests_failed++;
            $display("FAIL midreset_setup: eject_req_seen=%b eject_coin=%0d expected 1 1", seen, eject_coin);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (eject_req !== 1'b0 || l_select !== 1'b1 || l_vend !== 1'b0 || credit !== '0) begin
            tests_failed++;
            $display("FAIL midreset_drop: eject_req=%b l_select=%b l_vend=%b credit=%0d expected 0 1 0 0",
                     eject_req, l_select, l_vend, credit);
        end
        price = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

`ifdef SALES_TOTAL_EN
    task automatic test_sales_total();
        bit to;
        int sales_m;
        apply_reset();
        sales_m = 0;
        tests_run++;
        if (sales_total !== '0) begin
            tests_failed++;
            $display("FAIL sales_reset: got %0d expected 0", sales_total);
        end
        for (int i = 0; i < 3; i++) begin
            price = 100;
            tick();
            pulse_coins(1, 0, 0, 0);
            do_vend_ack();
            sales_m = (sales_m + 100) % (1 << SW);
            tests_run++;
            if (sales_total !== SW'(sales_m)) begin
                tests_failed++;
                $display("FAIL sales_vend[%0d]: got %0d expected %0d", i, sales_total, sales_m);
            end
            collect_change(to);
            finish_txn();
        end
        price = 100;
        tick();
        pulse_coins(0, 1, 0, 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        collect_change(to);
        finish_txn();
        tests_run++;
        if (sales_total !== SW'(sales_m)) begin
            tests_failed++;
            $display("FAIL sales_refund: got %0d expected %0d", sales_total, sales_m);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_vend();
        test_multi_coin();
        test_cancel();
        test_timeout();
        test_ignored_inputs();
        test_saturation();
        test_random();
        test_reset_mid_change();
`ifdef SALES_TOTAL_EN
        test_sales_total();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
- Transaction controller for the vending datapath.
- Accumulates debounced coin pulses against the selected price and sequences the vend handshake with the dispenser motor.
- Returns change or refunds one coin at a time through a hopper handshake; drives the select/pay/vend status lamps.
- Sits between the coin debouncers, the price decode and the display/lamp logic, all on one system clock.

Parameters:
- CREDIT_W, 11, width of credit/price/change arithmetic in cents.
- TIMEOUT_CYC, 1000000, idle cycles in PAY with no coin before automatic refund; 0 disables.
- SALES_W, 20, width of sales_total (used only with SALES_TOTAL_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- price  in  CREDIT_W  selected item price in cents; 0 = nothing selected
- coin_dollar  in  1  one-cycle pulse, +100
- coin_quarter  in  1  one-cycle pulse, +25
- coin_dime  in  1  one-cycle pulse, +10
- coin_nickel  in  1  one-cycle pulse, +5
- cancel  in  1  one-cycle pulse, abort and refund
- vend_req  out  1  dispense request to motor
- vend_ack  in  1  motor done, one-cycle pulse
- eject_req  out  1  hopper eject request
- eject_coin  out  2  0=dollar 1=quarter 2=dime 3=nickel, stable while eject_req
- eject_ack  in  1  hopper ejected coin, one-cycle pulse
- credit  out  CREDIT_W  current credit, or remaining change while in CHANGE
- l_select  out  1  high in IDLE
- l_pay  out  1  high in PAY
- l_vend  out  1  high in VEND, CHANGE, DONE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, credit=0, vend_req=0, eject_req=0, eject_coin=0, timeout counter=0, l_select=1, l_pay=0, l_vend=0. Reset mid-handshake drops requests immediately; any coins held are lost.
- IDLE:
  - coin and cancel pulses ignored.
  - price!=0 -> PAY next cycle.
- PAY:
  - Coin pulses in the same cycle all sum; credit updates one cycle after the pulse.
  - Credit saturates at 2^CREDIT_W-1.
  - Timeout counter clears on any coin and on PAY entry.
- PAY exits, priority highest first:
  - (a) cancel, or price==0 -> CHANGE with change=credit (full refund; straight to DONE path if credit==0).
  - (b) TIMEOUT_CYC!=0 and counter reaches TIMEOUT_CYC -> same as (a).
  - (c) price!=0 and credit>=price (compare uses the updated credit) -> latch price_l=price, -> VEND.
- VEND:
  - vend_req=1 from the first VEND cycle, held until vend_ack is sampled.
  - Coins and cancel ignored; price changes ignored (price_l used).
  - On vend_ack: vend_req=0 the next cycle, change=credit-price_l, -> CHANGE.
- CHANGE:
  - change==0 -> DONE.
  - Otherwise select the largest coin <= change (100, 25, 10, 5), assert eject_req with eject_coin.
  - On eject_ack: subtract the coin value, drop eject_req for at least one cycle, then re-evaluate.
  - Remainder <5 is discarded -> DONE (unreachable with legal coins).
  - eject_ack without eject_req is ignored.
- DONE: credit=0; wait for price==0 -> IDLE. Prevents an immediate re-vend on the held switch.
- Status lamps are decoded from registered state; exactly one of l_select/l_pay/l_vend is high at any time.

Optional Feature:
- Macro: SALES_TOTAL_EN.
- Defined:
  - adds output sales_total [SALES_W-1:0], reset 0.
  - adds price_l on each vend_ack cycle, wraps modulo 2^SALES_W.
  - refunds do not count.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then price=120; dollar, quarter pulses -> PAY, credit 100 then 125; VEND with vend_req=1; on vend_ack, CHANGE ejects one nickel (eject_coin=3); DONE; price=0 -> IDLE.
- price=55; dollar, dime, nickel pulses in one cycle -> credit=115, VEND next; after ack, change 60 ejected as quarter, quarter, dime in order, each waiting for eject_ack.
- price=300; two dollars, then cancel -> CHANGE refunds dollar, dollar; no vend_req ever asserted; credit ends 0.
- TIMEOUT_CYC=16, price=240, one dime then 16 idle cycles -> refund of one dime; price held at 240 -> DONE, no return to PAY until price=0.
- Coins pulsed while IDLE (price=0) and during VEND -> credit unchanged; reset asserted during CHANGE with eject_req=1 -> eject_req=0 and l_select=1 immediately.
- SALES_TOTAL_EN, SALES_W=8: three vends at price 100 -> sales_total 100, 200, 44 (wrap); a cancelled transaction leaves it unchanged.
